// File: rtl/color_matrix_pkg.sv
// Shared constants for the programmable 3x3 colour matrix: register map,
// BT.601 full-range default coefficients and the output range helper.
package color_matrix_pkg;

   localparam int FRAC_W_DEF = 16;

   // Register map for the configuration port
   localparam logic [3:0] ADDR_C00  = 4'd0;
   localparam logic [3:0] ADDR_C01  = 4'd1;
   localparam logic [3:0] ADDR_C02  = 4'd2;
   localparam logic [3:0] ADDR_C10  = 4'd3;
   localparam logic [3:0] ADDR_C11  = 4'd4;
   localparam logic [3:0] ADDR_C12  = 4'd5;
   localparam logic [3:0] ADDR_C20  = 4'd6;
   localparam logic [3:0] ADDR_C21  = 4'd7;
   localparam logic [3:0] ADDR_C22  = 4'd8;
   localparam logic [3:0] ADDR_OFF0 = 4'd9;
   localparam logic [3:0] ADDR_OFF1 = 4'd10;
   localparam logic [3:0] ADDR_OFF2 = 4'd11;

   // BT.601 full-range RGB->YCbCr, Q2.16, row-major
   localparam int DEF_C [9] = '{ 19595,  38470,   7471,
                                -11059, -21709,  32768,
                                 32768, -27439,  -5329};

   // Clamp to [0, 2^data_w-1] or keep the low data_w bits; caller narrows the result.
   function automatic logic [31:0] sat_or_wrap(input logic signed [63:0] value,
                                               input int unsigned        data_w,
                                               input logic               saturate);
      logic signed [63:0] max_v;
      max_v = (64'sd1 <<< data_w) - 64'sd1;
      if (!saturate) return value[31:0] & max_v[31:0];
      if (value < 0) return '0;
      if (value > max_v) return max_v[31:0];
      return value[31:0];
   endfunction

endpackage

// File: rtl/cm_row_mac.sv
// One output row of the colour matrix: three products, sum with rounding,
// shift back to integer, add offset and range-limit. Four ce-gated stages.
module cm_row_mac
   import color_matrix_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int COEF_W   = 18,
   parameter int FRAC_W   = FRAC_W_DEF,
   parameter bit SATURATE = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ce,
   input  logic [DATA_W-1:0]        in0,
   input  logic [DATA_W-1:0]        in1,
   input  logic [DATA_W-1:0]        in2,
   input  logic signed [COEF_W-1:0] coef0,
   input  logic signed [COEF_W-1:0] coef1,
   input  logic signed [COEF_W-1:0] coef2,
   input  logic signed [DATA_W:0]   off,
   output logic [DATA_W-1:0]        out
);

   localparam int PROD_W = DATA_W + 1 + COEF_W;
   localparam int SUM_W  = PROD_W + 2;
   localparam logic signed [SUM_W-1:0] ROUND_C = SUM_W'(longint'(1) <<< (FRAC_W - 1));

   logic [DATA_W-1:0]        x0_q, x1_q, x2_q;
   logic signed [PROD_W-1:0] p0_q, p1_q, p2_q;
   logic signed [DATA_W:0]   off2_q, off3_q;
   logic signed [SUM_W-1:0]  sum_q;
   logic signed [SUM_W-1:0]  shifted;
   logic signed [63:0]       res_wide;

   // Stage 4 arithmetic: floor shift gives round-half-up after the +0.5 in stage 3
   always_comb begin
      shifted  = sum_q >>> FRAC_W;
      res_wide = 64'(shifted) + 64'(off3_q);
   end

   // Pipeline registers; coefficients and offset are captured together at stage 2
   always_ff @(posedge clk) begin
      if (rst) begin
         x0_q   <= '0;
         x1_q   <= '0;
         x2_q   <= '0;
         p0_q   <= '0;
         p1_q   <= '0;
         p2_q   <= '0;
         off2_q <= '0;
         sum_q  <= '0;
         off3_q <= '0;
         out    <= '0;
      end else if (ce) begin
         x0_q   <= in0;
         x1_q   <= in1;
         x2_q   <= in2;
         p0_q   <= PROD_W'($signed({1'b0, x0_q})) * PROD_W'(coef0);
         p1_q   <= PROD_W'($signed({1'b0, x1_q})) * PROD_W'(coef1);
         p2_q   <= PROD_W'($signed({1'b0, x2_q})) * PROD_W'(coef2);
         off2_q <= off;
         sum_q  <= SUM_W'(p0_q) + SUM_W'(p1_q) + SUM_W'(p2_q) + ROUND_C;
         off3_q <= off2_q;
         out    <= DATA_W'(sat_or_wrap(res_wide, DATA_W, SATURATE));
      end
   end

endmodule

// File: rtl/color_matrix_3x3.sv
// Run-time programmable 3x3 colour-space converter with a shadow/active
// coefficient bank pair, frame-synchronous commit and aligned timing outputs.
module color_matrix_3x3
   import color_matrix_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int COEF_W   = 18,
   parameter int FRAC_W   = FRAC_W_DEF,
   parameter bit SATURATE = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ce,
   input  logic              de_in,
   input  logic              hsync_in,
   input  logic              vsync_in,
   input  logic [DATA_W-1:0] in0,
   input  logic [DATA_W-1:0] in1,
   input  logic [DATA_W-1:0] in2,
   input  logic              cfg_we,
   input  logic [3:0]        cfg_addr,
   input  logic [COEF_W-1:0] cfg_wdata,
   input  logic              cfg_commit,
   output logic              cfg_pending,
   output logic [DATA_W-1:0] out0,
   output logic [DATA_W-1:0] out1,
   output logic [DATA_W-1:0] out2,
   output logic              de_out,
   output logic              hsync_out,
   output logic              vsync_out
);

   localparam logic ST_IDLE    = 1'b0;
   localparam logic ST_PENDING = 1'b1;
   localparam logic signed [DATA_W:0] OFF_MID = (DATA_W + 1)'(longint'(1) <<< (DATA_W - 1));

   logic signed [COEF_W-1:0] shadow_c [9];
   logic signed [COEF_W-1:0] active_c [9];
   logic signed [DATA_W:0]   shadow_off [3];
   logic signed [DATA_W:0]   active_off [3];
   logic                     state_q, state_d;
   logic                     vsync_prev;
   logic                     frame_start, do_copy;
   logic [2:0]               tdly [4];
   logic [DATA_W-1:0]        row_out [3];

   // Commit FSM next state; a commit arriving with the copy re-arms the request
   always_comb begin
      frame_start = ce & vsync_in & ~vsync_prev;
      do_copy     = frame_start & (state_q == ST_PENDING);
      state_d     = state_q;
      case (state_q)
         ST_IDLE:    if (cfg_commit) state_d = ST_PENDING;
         ST_PENDING: if (do_copy && !cfg_commit) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   assign cfg_pending = (state_q == ST_PENDING);

   // Commit state and vsync edge history (history only advances with ce)
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         vsync_prev <= 1'b0;
      end else begin
         state_q <= state_d;
         if (ce) vsync_prev <= vsync_in;
      end
   end

   // Banks: the copy reads shadow before any same-edge write lands in it
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 9; i++) begin
            shadow_c[i] <= COEF_W'(DEF_C[i]);
            active_c[i] <= COEF_W'(DEF_C[i]);
         end
         shadow_off[0] <= '0;
         shadow_off[1] <= OFF_MID;
         shadow_off[2] <= OFF_MID;
         active_off[0] <= '0;
         active_off[1] <= OFF_MID;
         active_off[2] <= OFF_MID;
      end else begin
         if (do_copy) begin
            for (int i = 0; i < 9; i++) active_c[i] <= shadow_c[i];
            for (int i = 0; i < 3; i++) active_off[i] <= shadow_off[i];
         end
         if (cfg_we) begin
            case (cfg_addr)
               ADDR_C00, ADDR_C01, ADDR_C02,
               ADDR_C10, ADDR_C11, ADDR_C12,
               ADDR_C20, ADDR_C21, ADDR_C22: shadow_c[cfg_addr] <= cfg_wdata;
               ADDR_OFF0: shadow_off[0] <= cfg_wdata[DATA_W:0];
               ADDR_OFF1: shadow_off[1] <= cfg_wdata[DATA_W:0];
               ADDR_OFF2: shadow_off[2] <= cfg_wdata[DATA_W:0];
               default: ;
            endcase
         end
      end
   end

   // Timing delay matching the four data stages
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) tdly[i] <= '0;
      end else if (ce) begin
         tdly[0] <= {de_in, hsync_in, vsync_in};
         for (int i = 1; i < 4; i++) tdly[i] <= tdly[i-1];
      end
   end

   assign {de_out, hsync_out, vsync_out} = tdly[3];

   for (genvar k = 0; k < 3; k++) begin : g_row
      cm_row_mac #(
         .DATA_W   (DATA_W),
         .COEF_W   (COEF_W),
         .FRAC_W   (FRAC_W),
         .SATURATE (SATURATE)
      ) u_row (
         .clk   (clk),
         .rst   (rst),
         .ce    (ce),
         .in0   (in0),
         .in1   (in1),
         .in2   (in2),
         .coef0 (active_c[3*k]),
         .coef1 (active_c[3*k+1]),
         .coef2 (active_c[3*k+2]),
         .off   (active_off[k]),
         .out   (row_out[k])
      );
   end

   assign out0 = row_out[0];
   assign out1 = row_out[1];
   assign out2 = row_out[2];

endmodule
